// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared types and counter-index helpers for hazard_unit_param
// Revision   : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        TS_IDLE  = 2'd0,
        TS_DRAIN = 2'd1,
        TS_ACK   = 2'd2
    } ts_state_e;

    // Counters 0..n-1 track per-stage stall requests; the event counters follow.
    function automatic int ctr_redirect(input int n);
        return n;
    endfunction

    function automatic int ctr_ts(input int n);
        return n + 1;
    endfunction

    function automatic int ctr_drain(input int n);
        return n + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : up-counter that sticks at all-ones, clear has priority
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_unit_param.sv
// ============================================================================
// hazard_unit_param : N-stage stall/flush/redirect controller with draining
//                     thread switch and saturating performance counters
// Revision          : 1.0
// ============================================================================
`default_nettype none

module hazard_unit_param
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int SEL_WIDTH  = $clog2(NUM_STAGES + 3)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_STAGES-1:0]            stall_req,
    input  logic [NUM_STAGES-1:0]            redirect_req,
    input  logic [NUM_STAGES*ADDR_WIDTH-1:0] redirect_pc,
    output logic [NUM_STAGES-1:0]            redirect_ack,
    input  logic                             ts_req,
    input  logic [ADDR_WIDTH-1:0]            ts_pc,
    output logic                             ts_ack,
    output logic [NUM_STAGES-1:0]            stall,
    output logic [NUM_STAGES-1:0]            flush,
    output logic                             load_pc_we,
    output logic [ADDR_WIDTH-1:0]            load_pc_addr,
    input  logic [SEL_WIDTH-1:0]             ctr_sel,
    input  logic                             ctr_clear,
    output logic [CNT_WIDTH-1:0]             ctr_rdata
);

    localparam int NUM_CTRS     = NUM_STAGES + 3;
    localparam int IDX_W        = $clog2(NUM_STAGES);
    localparam int CTR_REDIRECT = ctr_redirect(NUM_STAGES);
    localparam int CTR_TS       = ctr_ts(NUM_STAGES);
    localparam int CTR_DRAIN    = ctr_drain(NUM_STAGES);

    ts_state_e              r_state;
    ts_state_e              w_state_next;
    logic [IDX_W-1:0]       r_drain_cnt;
    logic [IDX_W-1:0]       w_drain_cnt_next;
    logic [ADDR_WIDTH-1:0]  r_ts_pc;
    logic [ADDR_WIDTH-1:0]  w_ts_pc_next;

    logic [NUM_STAGES-1:0]  w_ds;
    logic                   w_win_valid;
    logic [IDX_W-1:0]       w_win_idx;
    logic [ADDR_WIDTH-1:0]  w_win_pc;
    logic                   w_accept;

    logic [NUM_CTRS-1:0]    w_ctr_inc;
    logic [CNT_WIDTH-1:0]   w_ctr_val [NUM_CTRS];
    logic [CNT_WIDTH-1:0]   w_sel_val;

    // A stage is held whenever it or anything older cannot complete.
    always_comb begin
        w_ds = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_ds[k] = |(stall_req >> k);
        end
    end

    // Ascending scan: the last qualifying stage seen is the oldest one.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        w_win_pc    = '0;
        for (int r = 0; r < NUM_STAGES; r++) begin
            if (redirect_req[r] && !w_ds[r]) begin
                w_win_valid = 1'b1;
                w_win_idx   = IDX_W'(r);
                w_win_pc    = redirect_pc[r*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign w_accept = rst_n && (r_state == TS_IDLE) && w_win_valid;

    always_comb begin
        stall        = w_ds;
        flush        = '0;
        redirect_ack = '0;
        load_pc_we   = 1'b0;
        load_pc_addr = '0;
        ts_ack       = 1'b0;

        for (int k = 1; k < NUM_STAGES; k++) begin
            flush[k] = w_ds[k-1] & ~w_ds[k];
        end

        if (w_accept) begin
            redirect_ack[w_win_idx] = 1'b1;
            load_pc_we              = 1'b1;
            load_pc_addr            = w_win_pc;
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (k <= int'(w_win_idx)) begin
                    stall[k] = 1'b0;
                    if (k >= 1) begin
                        flush[k] = 1'b1;
                    end
                end
            end
        end

        case (r_state)
            TS_DRAIN: begin
                stall[0] = 1'b1;
                flush[1] = 1'b1;
            end
            TS_ACK: begin
                ts_ack       = 1'b1;
                load_pc_we   = 1'b1;
                load_pc_addr = r_ts_pc;
                stall[0]     = 1'b0;
                flush[1]     = 1'b1;
            end
            default: ;
        endcase

        if (!rst_n) begin
            stall        = '0;
            flush        = {{(NUM_STAGES-1){1'b1}}, 1'b0};
            redirect_ack = '0;
            load_pc_we   = 1'b0;
            load_pc_addr = '0;
            ts_ack       = 1'b0;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        w_ts_pc_next     = r_ts_pc;
        case (r_state)
            TS_IDLE: begin
                if (ts_req) begin
                    w_state_next     = TS_DRAIN;
                    w_drain_cnt_next = IDX_W'(NUM_STAGES - 1);
                    w_ts_pc_next     = ts_pc;
                end
            end
            TS_DRAIN: begin
                // The cycle in which the count reaches zero is the last drain cycle.
                if (!w_ds[0] && (r_drain_cnt != '0)) begin
                    w_drain_cnt_next = r_drain_cnt - IDX_W'(1);
                end
                if (w_drain_cnt_next == '0) begin
                    w_state_next = TS_ACK;
                end
            end
            TS_ACK: begin
                w_state_next = TS_IDLE;
            end
            default: begin
                w_state_next = TS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= TS_IDLE;
            r_drain_cnt <= '0;
            r_ts_pc     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_cnt_next;
            r_ts_pc     <= w_ts_pc_next;
        end
    end

    always_comb begin
        w_ctr_inc                        = '0;
        w_ctr_inc[NUM_STAGES-1:0]        = stall_req;
        w_ctr_inc[CTR_REDIRECT]          = w_accept;
        w_ctr_inc[CTR_TS]                = (r_state == TS_ACK);
        w_ctr_inc[CTR_DRAIN]             = (r_state == TS_DRAIN);
    end

    for (genvar i = 0; i < NUM_CTRS; i++) begin : g_ctr
        sat_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_sat_counter (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (w_ctr_inc[i]),
            .clr   (ctr_clear),
            .count (w_ctr_val[i])
        );
    end

    // Indices beyond the last counter fall through to zero.
    always_comb begin
        w_sel_val = '0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            if (ctr_sel == SEL_WIDTH'(i)) begin
                w_sel_val = w_ctr_val[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_rdata <= '0;
        end else begin
            ctr_rdata <= w_sel_val;
        end
    end

endmodule

`default_nettype wire

// File: doc/hazard_unit_param.md
Name: hazard_unit_param

Overview:
Parametrised successor to the fixed 5-stage hazard controller. It takes per-stage stall and redirect requests for an N-stage in-order pipeline and produces stall and flush controls for every pipeline register. It also produces the PC-load command. Adds a draining thread-switch FSM (older instructions retire instead of being killed) and saturating per-hazard performance counters with a registered read port. Sits beside the core datapath in place of the hard-wired controller.

Parameters:
NUM_STAGES, 5, pipeline depth N (stage 0 = IF, N-1 = WB); legal 3..8
ADDR_WIDTH, 32, PC width
CNT_WIDTH, 32, width of each performance counter
SEL_WIDTH, $clog2(NUM_STAGES+3), counter-select width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
stall_req  in  N  bit k: stage k cannot complete this cycle (icache miss, lw hazard, dcache miss, ...)
redirect_req  in  N  bit r: stage r requests PC redirect; requester holds until accepted
redirect_pc  in  N*ADDR_WIDTH  slice r = target for redirect_req[r]
redirect_ack  out  N  one-hot: redirect from stage r accepted this cycle
ts_req  in  1  thread-switch request; level, sampled only in IDLE
ts_pc  in  ADDR_WIDTH  first PC of the incoming thread, captured with ts_req
ts_ack  out  1  one-cycle pulse: switch complete, new PC loaded
stall  out  N  bit k: hold the register feeding stage k (bit 0 = PC register)
flush  out  N  bit k: bubble the register feeding stage k (bit 0 always 0)
load_pc_we  out  1  load PC this cycle
load_pc_addr  out  ADDR_WIDTH  PC value to load
ctr_sel  in  SEL_WIDTH  counter index to read
ctr_clear  in  1  synchronous clear of all counters
ctr_rdata  out  CNT_WIDTH  selected counter, registered

Behaviour:
- ds[k] (downstream stall) = OR of stall_req[k..N-1]. stall[k] = ds[k], except as overridden below.
- Bubble rule: flush[k] = ds[k-1] & !ds[k] for k >= 1.
- Redirect arbitration, IDLE state only: the winner is the highest r with redirect_req[r] & !ds[r]; that is, the oldest stage wins. Younger requests are not acked.
- An accepted redirect at r drives:
  - redirect_ack[r] = 1
  - load_pc_we = 1, load_pc_addr = redirect_pc[r]
  - stall[0] = 0, stall[k] = 0 for k <= r
  - flush[k] = 1 for 1 <= k <= r
- Accept, PC load and flush all happen in the same cycle (combinational).
- With no accepted redirect and the FSM in IDLE, load_pc_we = 0 and load_pc_addr = 0.
- Thread-switch FSM, states IDLE, DRAIN, ACK:
  - IDLE -> DRAIN when ts_req = 1. On that edge, capture ts_pc into ts_pc_q and load drain_cnt = N-1. A redirect accepted in that same cycle is still honoured.
  - In DRAIN: stall[0] = 1 and flush[1] = 1. Older stages follow the normal stall/bubble rules. redirect_req is ignored (no ack, not counted). drain_cnt decrements only in cycles where ds[0] = 0.
  - DRAIN -> ACK when drain_cnt == 0.
  - In ACK, for one cycle: ts_ack = 1, load_pc_we = 1, load_pc_addr = ts_pc_q, stall[0] = 0, flush[1] = 1. Then return to IDLE.
  - ts_req held high after ACK starts a new switch on the next IDLE cycle.
- Counters, saturating at all-ones:
  - Index k < N: cycles with stall_req[k].
  - Index N: accepted redirects.
  - Index N+1: completed switches (ACK cycles).
  - Index N+2: cycles spent in DRAIN.
- ctr_clear takes priority over increment in the same cycle.
- ctr_rdata <= counter[ctr_sel] on each clk edge (1-cycle latency). An out-of-range ctr_sel reads 0.
- While rst_n = 0:
  - state = IDLE, all counters = 0, ctr_rdata = 0, ts_ack = 0, ts_pc_q = 0, drain_cnt = 0.
  - stall = 0, flush = all-ones except bit 0, load_pc_we = 0, redirect_ack = 0.
- Reset asserted mid-DRAIN abandons the switch; no ts_ack is issued.

Decomposition:
- Shared package hazard_pkg: ts_state_e enum (IDLE, DRAIN, ACK); counter index constants CTR_REDIRECT = N, CTR_TS = N+1, CTR_DRAIN = N+2, expressed as functions of N.
- One sub-module, sat_counter (CNT_WIDTH, inc, clr), instantiated N+3 times. Arbitration and the FSM stay in the top module.

Test Plan:
- All parameters at defaults (N = 5) unless stated.
- stall_req = 5'b01000 (dcache miss) for 3 cycles -> stall = 5'b01111, flush = 5'b10000 each cycle; ctr_sel = 3 reads 3 one cycle after the miss ends.
- redirect_req = 5'b00110, stall_req = 0, pc[2] = 0x400, pc[1] = 0x200 -> redirect_ack = 5'b00100, load_pc_addr = 0x400, flush = 5'b00110, stall = 0.
- redirect_req[1] = 1 with stall_req[3] = 1 -> no ack, load_pc_we = 0; ack arrives in the first cycle after stall_req[3] drops.
- ts_req with ts_pc = 0x1000, no stalls -> 4 DRAIN cycles with stall[0] = 1, then ts_ack and load_pc_addr = 0x1000 in cycle 5; redirect_req[1] is ignored during DRAIN. Repeat with stall_req[3] held 2 cycles mid-drain -> ts_ack arrives 2 cycles later.
- Counter saturation with CNT_WIDTH = 4: 20 stall_req[0] cycles -> reads 0xF. ctr_clear coinciding with an increment -> reads 0.
- Assert rst_n = 0 during DRAIN -> outputs take reset values immediately (async); no ts_ack after release; all counters read 0.
